maze_explorer_gen: RTL and testbench

Parametrised next-generation maze explorer for the e-Yantra maze-solving bot. It consumes relative wall sensing (left/mid/right) and emits one move per sensing handshake. The maze size, start pose, exit and wall-follow hand are parameters or runtime-selectable. It tracks its own position and facing, records visited dead ends in a per-cell bitmap, and only takes the exit once a dead-end target count is met. It sits between the sensor front-end and the motion controller.

---
 rtl/maze_pkg.sv | 23 ++
 rtl/maze_wall_follower.sv | 26 ++
 rtl/maze_explorer_gen.sv | 160 ++++++++++++++++
 tb/tb_maze_explorer_gen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze explorer: move codes, absolute directions and FSM states.
package maze_pkg;

    localparam logic [2:0] MV_NONE  = 3'b000;
    localparam logic [2:0] MV_FWD   = 3'b001;
    localparam logic [2:0] MV_LEFT  = 3'b010;
    localparam logic [2:0] MV_RIGHT = 3'b011;
    localparam logic [2:0] MV_UTURN = 3'b100;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR,
        ST_TOUT
    } state_t;

endpackage

// File: rtl/maze_wall_follower.sv
// Hand-rule decision from relative walls to a move code.
// Purely combinational; no handshake, result is consumed in the same cycle.
module maze_wall_follower
    import maze_pkg::*;
(
    input  logic       left,
    input  logic       mid,
    input  logic       right,
    input  logic       hand,
    output logic [2:0] move
);

    always_comb begin
        move = MV_UTURN;
        if (!hand) begin
            if (!left)       move = MV_LEFT;
            else if (!mid)   move = MV_FWD;
            else if (!right) move = MV_RIGHT;
        end else begin
            if (!right)      move = MV_RIGHT;
            else if (!mid)   move = MV_FWD;
            else if (!left)  move = MV_LEFT;
        end
    end

endmodule

// File: rtl/maze_explorer_gen.sv
// Wall-following maze explorer: one move per sensed cycle, tracks pose, dead ends and exit gating.
// Move and pose register on the sampling edge; no backpressure, the motion side must take every move.
module maze_explorer_gen
    import maze_pkg::*;
#(
    parameter int MAZE_W      = 9,
    parameter int MAZE_H      = 9,
    parameter int START_POS   = 76,
    parameter int START_DIR   = 0,
    parameter int EXIT_POS    = 4,
    parameter int EXIT_DIR    = 0,
    parameter int DEAD_TARGET = 0,
    parameter int MAX_STEPS   = 1023,
    localparam int PW = $clog2(MAZE_W * MAZE_H),
    localparam int DW = $clog2(MAZE_W * MAZE_H + 1),
    localparam int SW = $clog2(MAX_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hand,
    input  logic          sense_valid,
    input  logic          left,
    input  logic          mid,
    input  logic          right,
    output logic          move_valid,
    output logic [2:0]    move,
    output logic [PW-1:0] pos,
    output logic [1:0]    facing,
    output logic [DW-1:0] dead_cnt,
    output logic [SW-1:0] steps,
    output logic          done,
    output logic          err,
    output logic          timeout
);

    localparam int RW = $clog2(MAZE_H);
    localparam int CW = $clog2(MAZE_W);
    localparam logic [RW-1:0] START_ROW  = RW'(START_POS / MAZE_W);
    localparam logic [CW-1:0] START_COL  = CW'(START_POS % MAZE_W);
    localparam logic [1:0]    START_FACE = 2'(START_DIR);
    localparam logic [1:0]    EXIT_SIDE  = 2'(EXIT_DIR);
    localparam logic [PW-1:0] EXIT_IDX   = PW'(EXIT_POS);

    state_t                   state;
    logic                     hand_q;
    logic [RW-1:0]            row, row_nxt;
    logic [CW-1:0]            col, col_nxt;
    logic [MAZE_W*MAZE_H-1:0] dead_map;
    logic                     at_exit, mask_en, off_grid, is_exit, hit_max;
    logic                     w_left, w_mid, w_right;
    logic [1:0]               exit_rel, new_facing;
    logic [2:0]               dec_move;
    logic [SW-1:0]            steps_nxt;

    assign pos     = PW'(row) * PW'(MAZE_W) + PW'(col);
    assign at_exit = (pos == EXIT_IDX);
    assign mask_en = at_exit && ((32'(dead_cnt) + 32'd1) <= 32'(DEAD_TARGET));

    // Exit side seen relative to the bot; a side behind needs no masking.
    assign exit_rel = EXIT_SIDE - facing;
    assign w_left   = left  | (mask_en && exit_rel == 2'd3);
    assign w_mid    = mid   | (mask_en && exit_rel == 2'd0);
    assign w_right  = right | (mask_en && exit_rel == 2'd1);

    maze_wall_follower u_follow (
        .left  (w_left),
        .mid   (w_mid),
        .right (w_right),
        .hand  (hand_q),
        .move  (dec_move)
    );

    always_comb begin
        new_facing = facing;
        case (dec_move)
            MV_LEFT:  new_facing = facing - 2'd1;
            MV_RIGHT: new_facing = facing + 2'd1;
            MV_UTURN: new_facing = facing + 2'd2;
            default:  new_facing = facing;
        endcase
    end

    always_comb begin
        row_nxt  = row;
        col_nxt  = col;
        off_grid = 1'b0;
        case (new_facing)
            DIR_N: if (row == '0) off_grid = 1'b1; else row_nxt = row - RW'(1);
            DIR_E: if (col == CW'(MAZE_W - 1)) off_grid = 1'b1; else col_nxt = col + CW'(1);
            DIR_S: if (row == RW'(MAZE_H - 1)) off_grid = 1'b1; else row_nxt = row + RW'(1);
            default: if (col == '0) off_grid = 1'b1; else col_nxt = col - CW'(1);
        endcase
    end

    assign is_exit   = at_exit && (new_facing == EXIT_SIDE);
    assign steps_nxt = steps + SW'(1);
    assign hit_max   = (steps_nxt == SW'(MAX_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hand_q     <= 1'b0;
            row        <= START_ROW;
            col        <= START_COL;
            facing     <= START_FACE;
            dead_map   <= '0;
            dead_cnt   <= '0;
            steps      <= '0;
            move       <= MV_NONE;
            move_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            move       <= MV_NONE;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hand_q <= hand;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sense_valid) begin
                        move_valid <= 1'b1;
                        move       <= dec_move;
                        steps      <= steps_nxt;
                        if (dec_move == MV_UTURN && !dead_map[pos]) begin
                            dead_map[pos] <= 1'b1;
                            dead_cnt      <= dead_cnt + DW'(1);
                        end
                        if (is_exit) begin
                            facing <= new_facing;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            if (off_grid) begin
                                err   <= 1'b1;
                                state <= ST_ERR;
                            end else begin
                                facing <= new_facing;
                                row    <= row_nxt;
                                col    <= col_nxt;
                            end
                            // An off-grid move still counts towards the limit; ERR wins the state.
                            if (hit_max) begin
                                timeout <= 1'b1;
                                if (!off_grid) state <= ST_TOUT;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_explorer_gen.sv
// Bench for maze_explorer_gen: three instances (default, dead-end gated exit, short step limit)
// compared every cycle against an absolute-direction reference model, plus literal pins.
module tb_maze_explorer_gen;

    localparam int EXIT   = 4;
    localparam int EXIT_D = 0;
    localparam int W      = 9;
    localparam int H      = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [3];
    logic       start_v [3];
    logic       hand_v  [3];
    logic       sv_v    [3];
    logic       l_v     [3];
    logic       m_v     [3];
    logic       r_v     [3];

    logic       mvv_o  [3];
    logic [2:0] mv_o   [3];
    logic [6:0] pos_o  [3];
    logic [1:0] fac_o  [3];
    logic [6:0] dc_o   [3];
    logic [9:0] stp_o  [3];
    logic       done_o [3];
    logic       err_o  [3];
    logic       tout_o [3];
    logic [9:0] steps0, steps1;
    logic [1:0] steps2;

    assign stp_o[0] = steps0;
    assign stp_o[1] = steps1;
    assign stp_o[2] = {8'd0, steps2};

    maze_explorer_gen u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .hand(hand_v[0]),
        .sense_valid(sv_v[0]), .left(l_v[0]), .mid(m_v[0]), .right(r_v[0]),
        .move_valid(mvv_o[0]), .move(mv_o[0]), .pos(pos_o[0]), .facing(fac_o[0]),
        .dead_cnt(dc_o[0]), .steps(steps0), .done(done_o[0]), .err(err_o[0]), .timeout(tout_o[0])
    );

    maze_explorer_gen #(.DEAD_TARGET(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .hand(hand_v[1]),
        .sense_valid(sv_v[1]), .left(l_v[1]), .mid(m_v[1]), .right(r_v[1]),
        .move_valid(mvv_o[1]), .move(mv_o[1]), .pos(pos_o[1]), .facing(fac_o[1]),
        .dead_cnt(dc_o[1]), .steps(steps1), .done(done_o[1]), .err(err_o[1]), .timeout(tout_o[1])
    );

    maze_explorer_gen #(.MAX_STEPS(3)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .hand(hand_v[2]),
        .sense_valid(sv_v[2]), .left(l_v[2]), .mid(m_v[2]), .right(r_v[2]),
        .move_valid(mvv_o[2]), .move(mv_o[2]), .pos(pos_o[2]), .facing(fac_o[2]),
        .dead_cnt(dc_o[2]), .steps(steps2), .done(done_o[2]), .err(err_o[2]), .timeout(tout_o[2])
    );

    int tgt [3] = '{0, 1, 0};
    int mxs [3] = '{1023, 1023, 3};

    // st: 0 idle, 1 running, 2 finished
    typedef struct {
        int         st;
        bit         hnd;
        int         pos;
        int         fac;
        int         dcnt;
        int         steps;
        bit         done;
        bit         err;
        bit         tout;
        bit         mvv;
        int         mv;
        bit [127:0] dmap;
    } mdl_t;

    mdl_t md [3];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset(input int i);
        md[i].st = 0;    md[i].hnd = 1'b0; md[i].pos = 76;   md[i].fac = 0;
        md[i].dcnt = 0;  md[i].steps = 0;  md[i].done = 1'b0; md[i].err = 1'b0;
        md[i].tout = 1'b0; md[i].mvv = 1'b0; md[i].mv = 0;  md[i].dmap = '0;
    endtask

    task automatic model_step(input int i);
        mdl_t     m;
        bit [3:0] wall;
        int       order [4];
        int       t, d, row, col, k;
        bit       found, off;
        m = md[i];
        m.mvv = 1'b0;
        m.mv  = 0;
        if (m.st == 0) begin
            if (start_v[i]) begin
                m.st  = 1;
                m.hnd = hand_v[i];
            end
        end else if (m.st == 1 && sv_v[i]) begin
            // Walls in absolute compass terms; behind is always passable.
            wall = '0;
            wall[m.fac]           = m_v[i];
            wall[(m.fac + 3) % 4] = l_v[i];
            wall[(m.fac + 1) % 4] = r_v[i];
            if (m.pos == EXIT && m.dcnt < tgt[i]) wall[EXIT_D] = 1'b1;
            if (m.hnd) order = '{1, 0, 3, 2};
            else       order = '{3, 0, 1, 2};
            found = 1'b0;
            t = 2;
            for (k = 0; k < 4; k++) begin
                if (!found && (order[k] == 2 || !wall[(m.fac + order[k]) % 4])) begin
                    t = order[k];
                    found = 1'b1;
                end
            end
            d = (m.fac + t) % 4;
            m.mvv = 1'b1;
            m.mv  = (t == 0) ? 1 : (t == 3) ? 2 : (t == 1) ? 3 : 4;
            m.steps++;
            if (t == 2 && !m.dmap[m.pos]) begin
                m.dmap[m.pos] = 1'b1;
                m.dcnt++;
            end
            row = m.pos / W;
            col = m.pos % W;
            if (m.pos == EXIT && d == EXIT_D) begin
                m.fac  = d;
                m.done = 1'b1;
                m.st   = 2;
            end else begin
                off = (d == 0 && row == 0) || (d == 1 && col == W - 1) ||
                      (d == 2 && row == H - 1) || (d == 3 && col == 0);
                if (off) begin
                    m.err = 1'b1;
                    m.st  = 2;
                end else begin
                    m.fac = d;
                    m.pos = m.pos + ((d == 0) ? -W : (d == 1) ? 1 : (d == 2) ? W : -1);
                end
                if (m.steps == mxs[i]) begin
                    m.tout = 1'b1;
                    m.st   = 2;
                end
            end
        end
        md[i] = m;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) if (!rst_v[i]) model_step(i);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.move_valid", i), int'(mvv_o[i]), int'(md[i].mvv));
                chk($sformatf("u%0d.move", i),       int'(mv_o[i]),  md[i].mv);
                chk($sformatf("u%0d.pos", i),        int'(pos_o[i]), md[i].pos);
                chk($sformatf("u%0d.facing", i),     int'(fac_o[i]), md[i].fac);
                chk($sformatf("u%0d.dead_cnt", i),   int'(dc_o[i]),  md[i].dcnt);
                chk($sformatf("u%0d.steps", i),      int'(stp_o[i]), md[i].steps);
                chk($sformatf("u%0d.done", i),       int'(done_o[i]), int'(md[i].done));
                chk($sformatf("u%0d.err", i),        int'(err_o[i]),  int'(md[i].err));
                chk($sformatf("u%0d.timeout", i),    int'(tout_o[i]), int'(md[i].tout));
            end
        end
    end

    // Inputs change 1 time unit after the falling edge, clear of both sampling points.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int i);
        rst_v[i] = 1'b1;
        model_reset(i);
        tick();
        rst_v[i] = 1'b0;
    endtask

    task automatic do_start(input int i, input bit h);
        start_v[i] = 1'b1;
        hand_v[i]  = h;
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic sense(input int i, input bit l, input bit m, input bit r);
        sv_v[i] = 1'b1;
        l_v[i]  = l;
        m_v[i]  = m;
        r_v[i]  = r;
        tick();
        sv_v[i] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; hand_v[i] = 1'b0; sv_v[i] = 1'b0;
            l_v[i] = 1'b0; m_v[i] = 1'b0; r_v[i] = 1'b0;
            model_reset(i);
        end
        repeat (2) tick();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        chk_en = 1'b1;
        tick();

        chk("reset.pos", int'(pos_o[0]), 76);
        chk("reset.facing", int'(fac_o[0]), 0);
        chk("reset.move", int'(mv_o[0]), 0);
        chk("reset.flags", int'({done_o[0], err_o[0], tout_o[0], mvv_o[0]}), 0);

        // Left-hand walk, then a mid-run hand change that must be ignored.
        do_start(0, 1'b0);
        sense(0, 1'b0, 1'b1, 1'b1);
        chk("lh.move_left", int'(mv_o[0]), 2);
        chk("lh.facing", int'(fac_o[0]), 3);
        chk("lh.pos", int'(pos_o[0]), 75);
        sense(0, 1'b1, 1'b0, 1'b0);
        chk("lh.move_fwd", int'(mv_o[0]), 1);
        chk("lh.pos2", int'(pos_o[0]), 74);
        chk("lh.steps2", int'(stp_o[0]), 2);
        sense(0, 1'b1, 1'b1, 1'b0);
        chk("lh.pos3", int'(pos_o[0]), 65);
        hand_v[0] = 1'b1;
        sense(0, 1'b0, 1'b0, 1'b1);
        chk("lh.latched_hand", int'(pos_o[0]), 64);
        sense(0, 1'b1, 1'b0, 1'b1);
        chk("lh.pos5", int'(pos_o[0]), 63);

        // Asynchronous reset between edges.
        #2;
        rst_v[0] = 1'b1;
        model_reset(0);
        #1;
        chk("arst.pos", int'(pos_o[0]), 76);
        chk("arst.steps", int'(stp_o[0]), 0);
        chk("arst.move_valid", int'(mvv_o[0]), 0);
        tick();
        rst_v[0] = 1'b0;

        // Right-hand walk.
        do_start(0, 1'b1);
        sense(0, 1'b0, 1'b0, 1'b1);
        chk("rh.move", int'(mv_o[0]), 1);
        chk("rh.pos", int'(pos_o[0]), 67);
        hand_v[0] = 1'b0;
        sense(0, 1'b0, 1'b0, 1'b1);
        chk("rh.latched_hand", int'(pos_o[0]), 58);

        // Dead end on the bottom row turns into an off-grid step.
        do_reset(0);
        do_start(0, 1'b0);
        sense(0, 1'b1, 1'b1, 1'b1);
        chk("err.move", int'(mv_o[0]), 4);
        chk("err.flag", int'(err_o[0]), 1);
        chk("err.pos", int'(pos_o[0]), 76);
        chk("err.dead_cnt", int'(dc_o[0]), 1);
        sense(0, 1'b0, 1'b0, 1'b0);
        chk("err.no_move", int'(mvv_o[0]), 0);

        // Ungated exit straight up the middle column.
        do_reset(0);
        do_start(0, 1'b0);
        repeat (8) sense(0, 1'b1, 1'b0, 1'b1);
        chk("exit0.at_exit", int'(pos_o[0]), 4);
        sense(0, 1'b1, 1'b0, 1'b1);
        chk("exit0.done", int'(done_o[0]), 1);
        chk("exit0.pos", int'(pos_o[0]), 4);

        // Exit gated by one dead end.
        do_start(1, 1'b0);
        repeat (8) sense(1, 1'b1, 1'b0, 1'b1);
        sense(1, 1'b1, 1'b0, 1'b1);
        chk("gate.masked_uturn", int'(mv_o[1]), 4);
        chk("gate.pos", int'(pos_o[1]), 13);
        chk("gate.dead_cnt", int'(dc_o[1]), 1);
        sense(1, 1'b1, 1'b1, 1'b1);
        chk("gate.back_pos", int'(pos_o[1]), 4);
        sense(1, 1'b1, 1'b0, 1'b1);
        chk("gate.move", int'(mv_o[1]), 1);
        chk("gate.done", int'(done_o[1]), 1);
        chk("gate.steps", int'(stp_o[1]), 11);

        // Step limit of three.
        do_start(2, 1'b1);
        repeat (3) sense(2, 1'b1, 1'b0, 1'b1);
        chk("tout.flag", int'(tout_o[2]), 1);
        chk("tout.steps", int'(stp_o[2]), 3);
        chk("tout.pos", int'(pos_o[2]), 49);
        sense(2, 1'b1, 1'b0, 1'b1);
        chk("tout.no_move", int'(mv_o[2]), 0);

        // Random traffic on all instances with occasional resets.
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i] = (md[i].st == 2 && $urandom_range(3) == 0) || ($urandom_range(511) == 0);
                if (rst_v[i]) model_reset(i);
                start_v[i] = ($urandom_range(3) == 0);
                hand_v[i]  = 1'($urandom_range(1));
                sv_v[i]    = ($urandom_range(3) != 0);
                l_v[i]     = 1'($urandom_range(1));
                m_v[i]     = ($urandom_range(3) == 0);
                r_v[i]     = 1'($urandom_range(1));
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; start_v[i] = 1'b0; sv_v[i] = 1'b0;
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
